// File: rtl/axis_pkt_framer.sv
// Packet framer: cuts a raw AXI-Stream beat stream into len_i-beat packets,
// with an idle-timeout flush that closes a partial packet on its last beat.
module axis_pkt_framer #(
    parameter int DATA_WIDTH    = 32,
    parameter int LEN_WIDTH     = 16,
    parameter int TIMEOUT_WIDTH = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [LEN_WIDTH-1:0]     len_i,
    input  logic [TIMEOUT_WIDTH-1:0] timeout_i,
    input  logic [DATA_WIDTH-1:0]    s_axis_tdata,
    input  logic                     s_axis_tvalid,
    output logic                     s_axis_tready,
    output logic [DATA_WIDTH-1:0]    m_axis_tdata,
    output logic                     m_axis_tvalid,
    input  logic                     m_axis_tready,
    output logic                     m_axis_tlast,
    output logic [31:0]              pkt_cnt_o,
    output logic                     flush_o
);

    localparam logic [LEN_WIDTH-1:0]     LEN_ONE = {{(LEN_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [TIMEOUT_WIDTH-1:0] TO_ONE  = {{(TIMEOUT_WIDTH-1){1'b0}}, 1'b1};

    // hold register: a non-last beat waits here until its successor arrives
    logic                     h_vld_q, h_vld_d;
    logic [DATA_WIDTH-1:0]    h_data_q, h_data_d;
    logic                     h_last_q, h_last_d;

    // output register driving the master side
    logic                     o_vld_q, o_vld_d;
    logic [DATA_WIDTH-1:0]    o_data_q, o_data_d;
    logic                     o_last_q, o_last_d;

    // packet position, latched length, idle tracking, status
    logic [LEN_WIDTH-1:0]     cnt_q, cnt_d;
    logic [LEN_WIDTH-1:0]     len_lat_q, len_lat_d;
    logic [TIMEOUT_WIDTH-1:0] idle_q, idle_d;
    logic                     flush_q, flush_d;
    logic [31:0]              pkt_cnt_q, pkt_cnt_d;

    logic                     o_free;
    logic                     s_rdy;
    logic                     s_fire;
    logic                     m_fire;
    logic                     h_move;
    logic [LEN_WIDTH-1:0]     len_in;
    logic [LEN_WIDTH-1:0]     len_eff;
    logic                     beat_last;
    logic                     idle_run;
    logic                     flush_hit;

    // handshake qualifiers and packet-boundary decision for the incoming beat
    always_comb begin
        o_free    = !o_vld_q || m_axis_tready;
        s_rdy     = !rst_i && (!h_vld_q || o_free);
        s_fire    = s_axis_tvalid && s_rdy;
        m_fire    = o_vld_q && m_axis_tready;
        h_move    = h_vld_q && o_free && (h_last_q || s_fire);
        len_in    = (len_i == '0) ? LEN_ONE : len_i;
        len_eff   = (cnt_q == '0) ? len_in : len_lat_q;
        beat_last = (cnt_q == (len_eff - LEN_ONE));
        idle_run  = h_vld_q && !h_last_q && !s_axis_tvalid
                    && (timeout_i != '0);
        flush_hit = idle_run && (idle_q == (timeout_i - TO_ONE));
    end

    // next state of the hold register and the beat counter
    always_comb begin
        h_vld_d   = h_vld_q;
        h_data_d  = h_data_q;
        h_last_d  = h_last_q;
        cnt_d     = cnt_q;
        len_lat_d = len_lat_q;
        if (h_move) begin
            h_vld_d = 1'b0;
        end
        if (s_fire) begin
            h_vld_d   = 1'b1;
            h_data_d  = s_axis_tdata;
            h_last_d  = beat_last;
            len_lat_d = len_eff;
            cnt_d     = beat_last ? '0 : (cnt_q + LEN_ONE);
        end else if (flush_hit) begin
            h_last_d = 1'b1;
            cnt_d    = '0;
        end
    end

    // idle counter runs only while a non-last beat is stranded in H
    always_comb begin
        idle_d = idle_q;
        if (s_fire || !h_vld_q || h_last_q) begin
            idle_d = '0;
        end else if (idle_run) begin
            idle_d = flush_hit ? '0 : (idle_q + TO_ONE);
        end
    end

    // output register loads from H or empties once the beat is taken
    always_comb begin
        o_vld_d  = o_vld_q;
        o_data_d = o_data_q;
        o_last_d = o_last_q;
        if (h_move) begin
            o_vld_d  = 1'b1;
            o_data_d = h_data_q;
            o_last_d = h_last_q;
        end else if (m_fire) begin
            o_vld_d  = 1'b0;
            o_data_d = '0;
            o_last_d = 1'b0;
        end
    end

    // status: packet counter and flush pulse
    always_comb begin
        pkt_cnt_d = pkt_cnt_q + {31'b0, (m_fire && o_last_q)};
        flush_d   = flush_hit;
    end

    // state registers with synchronous reset
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            h_vld_q   <= 1'b0;
            h_data_q  <= '0;
            h_last_q  <= 1'b0;
            o_vld_q   <= 1'b0;
            o_data_q  <= '0;
            o_last_q  <= 1'b0;
            cnt_q     <= '0;
            len_lat_q <= LEN_ONE;
            idle_q    <= '0;
            flush_q   <= 1'b0;
            pkt_cnt_q <= '0;
        end else begin
            h_vld_q   <= h_vld_d;
            h_data_q  <= h_data_d;
            h_last_q  <= h_last_d;
            o_vld_q   <= o_vld_d;
            o_data_q  <= o_data_d;
            o_last_q  <= o_last_d;
            cnt_q     <= cnt_d;
            len_lat_q <= len_lat_d;
            idle_q    <= idle_d;
            flush_q   <= flush_d;
            pkt_cnt_q <= pkt_cnt_d;
        end
    end

    assign s_axis_tready = s_rdy;
    assign m_axis_tdata  = o_data_q;
    assign m_axis_tvalid = o_vld_q;
    assign m_axis_tlast  = o_last_q;
    assign pkt_cnt_o     = pkt_cnt_q;
    assign flush_o       = flush_q;

endmodule

// File: tb/tb_axis_pkt_framer.sv
// Directed bench for axis_pkt_framer: framing, timeout flush,
// random handshakes against a scoreboard, length changes and reset.
module tb_axis_pkt_framer;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] len;
    logic [15:0] tmo;
    logic [31:0] s_tdata;
    logic        s_tvalid;
    logic        s_tready;
    logic [31:0] m_tdata;
    logic        m_tvalid;
    logic        m_tready;
    logic        m_tlast;
    logic [31:0] pkt_cnt;
    logic        flush;

    always #5 clk = ~clk;

    axis_pkt_framer #(
        .DATA_WIDTH(32),
        .LEN_WIDTH(16),
        .TIMEOUT_WIDTH(16)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .len_i        (len),
        .timeout_i    (tmo),
        .s_axis_tdata (s_tdata),
        .s_axis_tvalid(s_tvalid),
        .s_axis_tready(s_tready),
        .m_axis_tdata (m_tdata),
        .m_axis_tvalid(m_tvalid),
        .m_axis_tready(m_tready),
        .m_axis_tlast (m_tlast),
        .pkt_cnt_o    (pkt_cnt),
        .flush_o      (flush)
    );

    int          n_assert = 0;
    int          n_fail   = 0;
    int          cyc_n    = 0;
    logic [31:0] oq_d[$];
    bit          oq_l[$];
    int          oq_c[$];
    int          aq_c[$];
    logic [31:0] sq_d[$];
    int          fl_cnt   = 0;
    int          fl_cyc   = 0;
    bit          rnd_rdy  = 1'b0;
    bit          stab     = 1'b0;
    bit          p_stall  = 1'b0;
    logic [31:0] p_data   = '0;
    logic        p_last   = 1'b0;

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // one clock: entered at edge+1, samples at edge+2, leaves at next edge+1
    task automatic cyc(output bit fired);
        if (rnd_rdy) m_tready = ($urandom_range(0, 1) == 1);
        #1;
        if (stab && p_stall) begin
            chk("stall_vld", 64'(m_tvalid), 64'(1'b1));
            chk("stall_data", 64'(m_tdata), 64'(p_data));
            chk("stall_last", 64'(m_tlast), 64'(p_last));
        end
        p_stall = m_tvalid && !m_tready;
        p_data  = m_tdata;
        p_last  = m_tlast;
        if (flush) begin
            fl_cnt++;
            fl_cyc = cyc_n;
        end
        if (m_tvalid && m_tready) begin
            oq_d.push_back(m_tdata);
            oq_l.push_back(m_tlast);
            oq_c.push_back(cyc_n);
        end
        fired = s_tvalid && s_tready;
        if (fired) begin
            aq_c.push_back(cyc_n);
            sq_d.push_back(s_tdata);
        end
        @(posedge clk);
        #1;
        cyc_n++;
    endtask

    task automatic beat(input logic [31:0] d);
        bit f;
        int n;
        f = 1'b0;
        n = 0;
        s_tvalid = 1'b1;
        s_tdata  = d;
        while (!f && n < 200) begin
            cyc(f);
            n++;
        end
        chk("beat_accept", 64'(f), 64'(1'b1));
        s_tvalid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit f;
        s_tvalid = 1'b0;
        repeat (n) cyc(f);
    endtask

    task automatic drain(input int want, input int lim);
        bit f;
        int n;
        n = 0;
        s_tvalid = 1'b0;
        while (oq_d.size() < want && n < lim) begin
            cyc(f);
            n++;
        end
        idle(3);
        chk("drain_count", 64'(oq_d.size()), 64'(want));
    endtask

    task automatic clr();
        oq_d.delete();
        oq_l.delete();
        oq_c.delete();
        aq_c.delete();
        sq_d.delete();
        fl_cnt = 0;
    endtask

    initial begin
        logic [31:0] pk0;
        rst      = 1'b1;
        len      = 16'd4;
        tmo      = 16'd0;
        s_tdata  = '0;
        s_tvalid = 1'b0;
        m_tready = 1'b1;

        // reset state
        repeat (3) @(posedge clk);
        #2;
        chk("rst_s_tready", 64'(s_tready), 64'(1'b0));
        chk("rst_m_tvalid", 64'(m_tvalid), 64'(1'b0));
        chk("rst_m_tdata", 64'(m_tdata), 64'(32'h0));
        chk("rst_m_tlast", 64'(m_tlast), 64'(1'b0));
        chk("rst_pkt_cnt", 64'(pkt_cnt), 64'(32'h0));
        chk("rst_flush", 64'(flush), 64'(1'b0));
        @(posedge clk);
        #1;
        rst = 1'b0;

        // len 4, back-to-back 8 beats
        clr();
        for (int i = 0; i < 8; i++) beat(32'h1000_0000 + 32'(i));
        drain(8, 50);
        for (int i = 0; i < 8; i++) begin
            chk("s1_data", 64'(oq_d[i]), 64'(32'h1000_0000 + 32'(i)));
            chk("s1_last", 64'(oq_l[i]), 64'(i == 3 || i == 7));
            chk("s1_latency", 64'(oq_c[i] - aq_c[i]), 64'(2));
        end
        chk("s1_thruput", 64'(oq_c[7] - oq_c[0]), 64'(7));
        chk("s1_pkt_cnt", 64'(pkt_cnt), 64'(32'd2));

        // len 8, timeout 10, 3 beats then idle -> flush
        clr();
        len = 16'd8;
        tmo = 16'd10;
        for (int i = 0; i < 3; i++) beat(32'h2000_0000 + 32'(i));
        idle(20);
        chk("s2_flush_cnt", 64'(fl_cnt), 64'(1));
        chk("s2_flush_cyc", 64'(fl_cyc), 64'(aq_c[2] + 11));
        chk("s2_out_cnt", 64'(oq_d.size()), 64'(3));
        for (int i = 0; i < 3; i++) begin
            chk("s2_data", 64'(oq_d[i]), 64'(32'h2000_0000 + 32'(i)));
            chk("s2_last", 64'(oq_l[i]), 64'(i == 2));
        end
        chk("s2_d2_cyc", 64'(oq_c[2]), 64'(aq_c[2] + 12));
        chk("s2_pkt_cnt", 64'(pkt_cnt), 64'(32'd3));
        clr();
        for (int i = 0; i < 8; i++) beat(32'h2100_0000 + 32'(i));
        drain(8, 50);
        for (int i = 0; i < 8; i++) begin
            chk("s2b_data", 64'(oq_d[i]), 64'(32'h2100_0000 + 32'(i)));
            chk("s2b_last", 64'(oq_l[i]), 64'(i == 7));
        end
        chk("s2b_pkt_cnt", 64'(pkt_cnt), 64'(32'd4));
        chk("s2b_flush_cnt", 64'(fl_cnt), 64'(0));

        // 4th beat lands on the flush cycle -> no flush
        clr();
        for (int i = 0; i < 3; i++) beat(32'h3000_0000 + 32'(i));
        idle(9);
        for (int i = 3; i < 8; i++) beat(32'h3000_0000 + 32'(i));
        drain(8, 50);
        chk("s3_acc_cyc", 64'(aq_c[3]), 64'(aq_c[2] + 10));
        chk("s3_flush_cnt", 64'(fl_cnt), 64'(0));
        for (int i = 0; i < 8; i++) begin
            chk("s3_data", 64'(oq_d[i]), 64'(32'h3000_0000 + 32'(i)));
            chk("s3_last", 64'(oq_l[i]), 64'(i == 7));
        end
        chk("s3_pkt_cnt", 64'(pkt_cnt), 64'(32'd5));

        // len 3, random valid/ready, 300 beats
        clr();
        len     = 16'd3;
        tmo     = 16'd0;
        pk0     = pkt_cnt;
        rnd_rdy = 1'b1;
        stab    = 1'b1;
        for (int i = 0; i < 300; i++) begin
            while ($urandom_range(0, 9) >= 7) idle(1);
            beat($urandom());
        end
        drain(300, 5000);
        for (int i = 0; i < 300; i++) begin
            chk("s4_data", 64'(oq_d[i]), 64'(sq_d[i]));
            chk("s4_last", 64'(oq_l[i]), 64'((i % 3) == 2));
        end
        chk("s4_pkt_cnt", 64'(pkt_cnt - pk0), 64'(32'd100));
        rnd_rdy  = 1'b0;
        stab     = 1'b0;
        m_tready = 1'b1;
        idle(2);

        // len 0 -> every beat is a packet
        clr();
        len = 16'd0;
        pk0 = pkt_cnt;
        for (int i = 0; i < 4; i++) beat(32'h5000_0000 + 32'(i));
        drain(4, 50);
        for (int i = 0; i < 4; i++) begin
            chk("s5_last", 64'(oq_l[i]), 64'(1'b1));
        end
        chk("s5_pkt_cnt", 64'(pkt_cnt - pk0), 64'(32'd4));

        // len 4 -> 2 after first beat: packet of 4 then of 2
        clr();
        len = 16'd4;
        beat(32'h5100_0000);
        len = 16'd2;
        for (int i = 1; i < 6; i++) beat(32'h5100_0000 + 32'(i));
        drain(6, 50);
        for (int i = 0; i < 6; i++) begin
            chk("s5b_data", 64'(oq_d[i]), 64'(32'h5100_0000 + 32'(i)));
            chk("s5b_last", 64'(oq_l[i]), 64'(i == 3 || i == 5));
        end

        // reset while H and O hold a partial packet
        clr();
        len      = 16'd4;
        m_tready = 1'b0;
        beat(32'h6000_0000);
        beat(32'h6000_0001);
        #1;
        chk("s6_pre_tvalid", 64'(m_tvalid), 64'(1'b1));
        chk("s6_pre_tready", 64'(s_tready), 64'(1'b0));
        rst = 1'b1;
        #1;
        chk("s6_rst_tready", 64'(s_tready), 64'(1'b0));
        @(posedge clk);
        #1;
        chk("s6_rst_tvalid", 64'(m_tvalid), 64'(1'b0));
        chk("s6_rst_tdata", 64'(m_tdata), 64'(32'h0));
        chk("s6_rst_tlast", 64'(m_tlast), 64'(1'b0));
        chk("s6_rst_pkt", 64'(pkt_cnt), 64'(32'h0));
        chk("s6_rst_flush", 64'(flush), 64'(1'b0));
        rst      = 1'b0;
        m_tready = 1'b1;
        clr();
        len = 16'd2;
        beat(32'h6100_0000);
        beat(32'h6100_0001);
        drain(2, 50);
        chk("s6_d0", 64'(oq_d[0]), 64'(32'h6100_0000));
        chk("s6_l0", 64'(oq_l[0]), 64'(1'b0));
        chk("s6_d1", 64'(oq_d[1]), 64'(32'h6100_0001));
        chk("s6_l1", 64'(oq_l[1]), 64'(1'b1));
        chk("s6_pkt_cnt", 64'(pkt_cnt), 64'(32'd1));

        // timeout 0: idle partial beat is held indefinitely
        clr();
        len = 16'd4;
        tmo = 16'd0;
        beat(32'h7000_0000);
        idle(60);
        chk("s7_flush_cnt", 64'(fl_cnt), 64'(0));
        chk("s7_out_cnt", 64'(oq_d.size()), 64'(0));
        chk("s7_tvalid", 64'(m_tvalid), 64'(1'b0));
        chk("s7_tready", 64'(s_tready), 64'(1'b1));

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
